// File: rtl/logic_gate_pkg.sv
// Shared widths, result bit positions and reset value for the two-input gate evaluator.
package logic_gate_pkg;

    localparam int IN_W     = 2;
    localparam int RESULT_W = 4;

    localparam int IDX_AND  = 0;
    localparam int IDX_OR   = 1;
    localparam int IDX_XOR  = 2;
    localparam int IDX_NAND = 3;

    localparam logic [RESULT_W-1:0] RESULT_RESET = 4'b0000;

endpackage : logic_gate_pkg

// File: rtl/logic_gate_if.sv
// Operand/result bundle between a source (master) and the gate evaluator (slave).
interface logic_gate_if;
    import logic_gate_pkg::*;

    logic [IN_W-1:0]     input_a;
    logic                in_valid;
    logic [RESULT_W-1:0] result;
    logic                out_valid;

    modport master (
        output input_a,
        output in_valid,
        input  result,
        input  out_valid
    );

    modport slave (
        input  input_a,
        input  in_valid,
        output result,
        output out_valid
    );

endinterface : logic_gate_if

// File: rtl/logic_gate_core.sv
// Purely combinational map from the operand pair {X,Y} to the AND/OR/XOR/NAND vector.
module logic_gate_core
    import logic_gate_pkg::*;
(
    input  logic [IN_W-1:0]     operands,
    output logic [RESULT_W-1:0] gates
);

    logic op_x;
    logic op_y;

    assign op_x = operands[1];
    assign op_y = operands[0];

    // Plain bitwise operators so X/Z on the operands propagate unmasked.
    assign gates[IDX_AND]  = op_x & op_y;
    assign gates[IDX_OR]   = op_x | op_y;
    assign gates[IDX_XOR]  = op_x ^ op_y;
    assign gates[IDX_NAND] = ~(op_x & op_y);

endmodule : logic_gate_core

// File: rtl/logic_gate.sv
// Gate evaluator top: core plus either a registered (1-cycle) or combinational output stage.
module logic_gate
    import logic_gate_pkg::*;
#(
    parameter int REGISTER_OUTPUT = 1
) (
    input  logic         clk,
    input  logic         rst,
    logic_gate_if.slave  bus
);

    logic [RESULT_W-1:0] gate_vec;

    logic_gate_core u_core (
        .operands (bus.input_a),
        .gates    (gate_vec)
    );

    generate
        if (REGISTER_OUTPUT != 0) begin : g_registered
            logic [RESULT_W-1:0] result_q;
            logic                valid_q;

            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clk) begin
                if (rst) begin
                    result_q <= RESULT_RESET;
                    valid_q  <= 1'b0;
                end else if (bus.in_valid) begin
                    result_q <= gate_vec;
                    valid_q  <= 1'b1;
                end else begin
                    // result_q deliberately holds; only the qualifier drops.
                    valid_q  <= 1'b0;
                end
            end

            assign bus.result    = result_q;
            assign bus.out_valid = valid_q;
        end else begin : g_combinational
            assign bus.result    = gate_vec;
            assign bus.out_valid = bus.in_valid & ~rst;
        end
    endgenerate

endmodule : logic_gate

// File: tb/tb_logic_gate.sv
// Self-checking bench for logic_gate: registered instance plus a combinational-mode instance.
module tb_logic_gate;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    // Reference state for the registered instance.
    logic [3:0] exp_result;
    logic       exp_valid;

    logic_gate_if bus_r ();
    logic_gate_if bus_c ();

    logic_gate #(.REGISTER_OUTPUT(1)) dut_reg (
        .clk (clk),
        .rst (rst),
        .bus (bus_r.slave)
    );

    logic_gate #(.REGISTER_OUTPUT(0)) dut_comb (
        .clk (clk),
        .rst (rst),
        .bus (bus_c.slave)
    );

    always #5 clk = ~clk;

    // Reference gate function from the count of set operand bits.
    function automatic logic [3:0] ref_gates(input logic [1:0] a);
        int ones;
        logic [3:0] r;
        ones = int'(a[1]) + int'(a[0]);
        r[0] = (ones == 2);
        r[1] = (ones >= 1);
        r[2] = (ones == 1);
        r[3] = (ones != 2);
        return r;
    endfunction

    task automatic check4(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check1(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One clock of stimulus on the registered instance, then compare against the model.
    task automatic step(input logic [1:0] a, input logic v, input logic r, input string tag);
        @(negedge clk);
        bus_r.input_a  = a;
        bus_r.in_valid = v;
        rst            = r;
        @(posedge clk);
        if (r) begin
            exp_result = 4'b0000;
            exp_valid  = 1'b0;
        end else if (v) begin
            exp_result = ref_gates(a);
            exp_valid  = 1'b1;
        end else begin
            exp_valid  = 1'b0;
        end
        #1;
        check4({tag, "_result"}, bus_r.result, exp_result);
        check1({tag, "_valid"}, bus_r.out_valid, exp_valid);
    endtask

    initial begin
        logic [1:0] sweep [4];
        logic [3:0] want  [4];
        logic [1:0] ra;
        logic       rv;
        logic       rr;

        exp_result     = 4'b0000;
        exp_valid      = 1'b0;
        bus_r.input_a  = 2'b11;
        bus_r.in_valid = 1'b1;
        bus_c.input_a  = 2'b00;
        bus_c.in_valid = 1'b0;

        // Reset held three cycles with a valid operand present.
        for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 1'b1, "reset");

        // Exhaustive sweep, back-to-back, with literal expectations.
        sweep = '{2'b11, 2'b10, 2'b01, 2'b00};
        want  = '{4'b0011, 4'b1110, 4'b1110, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            step(sweep[i], 1'b1, 1'b0, "sweep");
            check4("sweep_literal", bus_r.result, want[i]);
            check1("sweep_and",  bus_r.result[0], sweep[i][1] & sweep[i][0]);
            check1("sweep_or",   bus_r.result[1], sweep[i][1] | sweep[i][0]);
            check1("sweep_xor",  bus_r.result[2], sweep[i][1] ^ sweep[i][0]);
            check1("sweep_nand", bus_r.result[3], ~(sweep[i][1] & sweep[i][0]));
        end

        // Hold: invalid input must not disturb the stored result.
        step(2'b11, 1'b1, 1'b0, "hold_load");
        step(2'b00, 1'b0, 1'b0, "hold_idle");
        check4("hold_literal", bus_r.result, 4'b0011);

        // Reset mid-stream takes priority over a valid input.
        step(2'b10, 1'b1, 1'b0, "mid_pre");
        step(2'b10, 1'b1, 1'b1, "mid_rst");
        check4("mid_rst_literal", bus_r.result, 4'b0000);
        step(2'b10, 1'b1, 1'b0, "mid_post");
        check4("mid_post_literal", bus_r.result, 4'b1110);

        // Randomized traffic with occasional idle cycles and resets.
        for (int i = 0; i < 200; i++) begin
            ra = 2'($urandom_range(0, 3));
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 15) == 0);
            step(ra, rv, rr, "rand");
        end

        // Combinational instance: result tracks input_a with no clock involvement.
        @(negedge clk);
        rst = 1'b1;
        bus_c.in_valid = 1'b0;
        sweep = '{2'b00, 2'b01, 2'b10, 2'b11};
        want  = '{4'b1000, 4'b1110, 4'b1110, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            bus_c.input_a = sweep[i];
            #1;
            check4("comb_literal", bus_c.result, want[i]);
            check4("comb_model", bus_c.result, ref_gates(sweep[i]));
        end

        // out_valid = in_valid & ~rst for every combination.
        for (int i = 0; i < 4; i++) begin
            rst            = i[1];
            bus_c.in_valid = i[0];
            #1;
            check1("comb_valid", bus_c.out_valid, i[0] & ~i[1]);
        end

        for (int i = 0; i < 40; i++) begin
            bus_c.input_a = 2'($urandom_range(0, 3));
            rst           = $urandom_range(0, 1) != 0;
            #1;
            check4("comb_rand", bus_c.result, ref_gates(bus_c.input_a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_logic_gate
